// File: rtl/reg_file_ctrl_fsm.sv
// Control sequencer for the shared-bus register-file datapath. It runs one
// register, immediate or move instruction at a time and checks register indices.
module reg_file_ctrl_fsm #(
  parameter int DATA_W  = 16,
  parameter int NREG    = 4,
  parameter int PARAM_W = 6
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic [3:0]         OPCODE,
  input  logic [PARAM_W-1:0] P1,
  input  logic [PARAM_W-1:0] P2,
  output logic               PCINC,
  output logic [NREG-1:0]    RI_OUT,
  output logic [NREG-1:0]    RI_IN,
  output logic               ALU_REG1,
  output logic               ALU_REG2,
  output logic               ALU_REGO,
  output logic               ALU_TRI,
  output logic               IMM_TRI,
  output logic [DATA_W-1:0]  IMM_OUT,
  output logic [2:0]         ALU_OP,
  output logic               BUSY,
  output logic               FINISH,
  output logic               ERR,
  output logic [2:0]         state_dbg
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [31:0] NREG_U = NREG;

  // START/ready handshake: START is a request that is taken only while the
  // sequencer sits in IDLE; in any other state it is ignored and never queued.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_EXEC   = 3'd4,
    S_WRITE  = 3'd5,
    S_MOVE   = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t state, nxt;

  logic [3:0]         op_q;
  logic [PARAM_W-1:0] p1_q, p2_q;
  logic               imm_mode, idx_err, set_err;
  logic [NREG-1:0]    p1_hot, p2_hot;

  logic            d_pcinc, d_reg1, d_reg2, d_rego, d_alu_tri, d_imm_tri;
  logic            d_busy, d_finish;
  logic [NREG-1:0] d_ri_out, d_ri_in;
  logic [2:0]      d_alu_op;

  assign imm_mode  = op_q[3];
  // Comparing the whole parameter field also catches nonzero bits above IDX_W.
  assign idx_err   = (32'(p1_q) >= NREG_U) || (!imm_mode && (32'(p2_q) >= NREG_U));
  assign p1_hot    = NREG'(1) << p1_q[IDX_W-1:0];
  assign p2_hot    = NREG'(1) << p2_q[IDX_W-1:0];
  assign state_dbg = state;

  always_comb begin
    nxt     = state;
    set_err = 1'b0;
    case (state)
      S_IDLE:   if (START) nxt = S_FETCH;
      S_FETCH: begin
        if (idx_err) begin
          nxt     = S_DONE;
          set_err = 1'b1;
        end else if (op_q[2:0] == 3'b111) begin
          nxt = S_MOVE;
        end else begin
          nxt = S_LOAD_A;
        end
      end
      S_LOAD_A: nxt = S_LOAD_B;
      S_LOAD_B: nxt = S_EXEC;
      S_EXEC:   nxt = S_WRITE;
      S_WRITE:  nxt = S_DONE;
      S_MOVE:   nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they register together with it.
  always_comb begin
    d_pcinc   = (nxt == S_FETCH);
    d_busy    = (nxt != S_IDLE);
    d_finish  = (nxt == S_DONE);
    d_ri_out  = '0;
    d_ri_in   = '0;
    d_reg1    = 1'b0;
    d_reg2    = 1'b0;
    d_rego    = 1'b0;
    d_alu_tri = 1'b0;
    d_imm_tri = 1'b0;
    d_alu_op  = 3'b000;
    case (nxt)
      S_LOAD_A: begin
        d_ri_out = p1_hot;
        d_reg1   = 1'b1;
      end
      S_LOAD_B: begin
        d_ri_out  = imm_mode ? '0 : p2_hot;
        d_imm_tri = imm_mode;
        d_reg2    = 1'b1;
      end
      S_EXEC:  d_rego = 1'b1;
      S_WRITE: begin
        d_alu_tri = 1'b1;
        d_ri_in   = p1_hot;
      end
      S_MOVE: begin
        d_ri_out  = imm_mode ? '0 : p2_hot;
        d_imm_tri = imm_mode;
        d_ri_in   = p1_hot;
      end
      default: ;
    endcase
    if (nxt == S_LOAD_A || nxt == S_LOAD_B || nxt == S_EXEC || nxt == S_WRITE)
      d_alu_op = op_q[2:0];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      op_q     <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      IMM_OUT  <= '0;
      ERR      <= 1'b0;
      PCINC    <= 1'b0;
      RI_OUT   <= '0;
      RI_IN    <= '0;
      ALU_REG1 <= 1'b0;
      ALU_REG2 <= 1'b0;
      ALU_REGO <= 1'b0;
      ALU_TRI  <= 1'b0;
      IMM_TRI  <= 1'b0;
      ALU_OP   <= 3'b000;
      BUSY     <= 1'b0;
      FINISH   <= 1'b0;
    end else begin
      state    <= nxt;
      PCINC    <= d_pcinc;
      RI_OUT   <= d_ri_out;
      RI_IN    <= d_ri_in;
      ALU_REG1 <= d_reg1;
      ALU_REG2 <= d_reg2;
      ALU_REGO <= d_rego;
      ALU_TRI  <= d_alu_tri;
      IMM_TRI  <= d_imm_tri;
      ALU_OP   <= d_alu_op;
      BUSY     <= d_busy;
      FINISH   <= d_finish;
      if (state == S_IDLE && START) begin
        op_q    <= OPCODE;
        p1_q    <= P1;
        p2_q    <= P2;
        IMM_OUT <= DATA_W'($signed(P2));
        ERR     <= 1'b0;
      end else if (set_err) begin
        ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_ctrl_fsm.sv
// Bench for reg_file_ctrl_fsm: each instruction is expanded into its expected
// per-cycle bus-transfer schedule and compared cycle by cycle with the DUT.
module tb_reg_file_ctrl_fsm;

  localparam int VW = 36;

  logic        CLK, RESET_N, START;
  logic [3:0]  OPCODE;
  logic [5:0]  P1, P2;

  logic        PCINC, ALU_REG1, ALU_REG2, ALU_REGO, ALU_TRI, IMM_TRI, BUSY, FINISH, ERR;
  logic [3:0]  RI_OUT, RI_IN;
  logic [15:0] IMM_OUT;
  logic [2:0]  ALU_OP, state_dbg;

  logic        pcinc3, reg1_3, reg2_3, rego3, alu_tri3, imm_tri3, busy3, finish3, err3;
  logic [2:0]  ri_out3, ri_in3;
  logic [15:0] imm_out3;
  logic [2:0]  alu_op3, state_dbg3;

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] exp3_q[$];
  logic          last_err;
  logic [15:0]   last_imm;

  reg_file_ctrl_fsm #(.DATA_W(16), .NREG(4), .PARAM_W(6)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .OPCODE(OPCODE), .P1(P1), .P2(P2),
    .PCINC(PCINC), .RI_OUT(RI_OUT), .RI_IN(RI_IN), .ALU_REG1(ALU_REG1),
    .ALU_REG2(ALU_REG2), .ALU_REGO(ALU_REGO), .ALU_TRI(ALU_TRI), .IMM_TRI(IMM_TRI),
    .IMM_OUT(IMM_OUT), .ALU_OP(ALU_OP), .BUSY(BUSY), .FINISH(FINISH), .ERR(ERR),
    .state_dbg(state_dbg)
  );

  reg_file_ctrl_fsm #(.DATA_W(16), .NREG(3), .PARAM_W(6)) u_dut3 (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .OPCODE(OPCODE), .P1(P1), .P2(P2),
    .PCINC(pcinc3), .RI_OUT(ri_out3), .RI_IN(ri_in3), .ALU_REG1(reg1_3),
    .ALU_REG2(reg2_3), .ALU_REGO(rego3), .ALU_TRI(alu_tri3), .IMM_TRI(imm_tri3),
    .IMM_OUT(imm_out3), .ALU_OP(alu_op3), .BUSY(busy3), .FINISH(finish3), .ERR(err3),
    .state_dbg(state_dbg3)
  );

  logic [VW-1:0] obs, obs3;
  assign obs  = {PCINC, RI_OUT, RI_IN, ALU_REG1, ALU_REG2, ALU_REGO, ALU_TRI, IMM_TRI,
                 ALU_OP, BUSY, FINISH, ERR, IMM_OUT};
  assign obs3 = {pcinc3, 1'b0, ri_out3, 1'b0, ri_in3, reg1_3, reg2_3, rego3, alu_tri3,
                 imm_tri3, alu_op3, busy3, finish3, err3, imm_out3};

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec(
    input logic pcinc, input logic [3:0] ri_out, input logic [3:0] ri_in,
    input logic r1, input logic r2, input logic ro, input logic atri, input logic itri,
    input logic [2:0] op, input logic busy, input logic fin, input logic err,
    input logic [15:0] imm);
    return {pcinc, ri_out, ri_in, r1, r2, ro, atri, itri, op, busy, fin, err, imm};
  endfunction

  // Reference: the list of bus transfers one instruction performs, cycle c1 onward,
  // ending with the first IDLE cycle after completion.
  task automatic model_instr(input bit third, input int nreg, input logic [3:0] op,
                             input logic [5:0] p1, input logic [5:0] p2);
    logic [VW-1:0] q[$];
    logic [15:0]   imm;
    logic          immm, bad;
    logic [3:0]    dst, src;
    logic [2:0]    f;
    imm  = {{10{p2[5]}}, p2};
    immm = op[3];
    bad  = (int'(p1) >= nreg) || (!immm && int'(p2) >= nreg);
    dst  = 4'b0001 << p1[1:0];
    src  = immm ? 4'b0000 : (4'b0001 << p2[1:0]);
    f    = op[2:0];
    q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, imm));
    if (bad) begin
      q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, imm));
    end else if (f == 3'b111) begin
      q.push_back(vec(0, src, dst, 0, 0, 0, 0, immm, 0, 1, 0, 0, imm));
      q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, imm));
    end else begin
      q.push_back(vec(0, dst, 0, 1, 0, 0, 0, 0, f, 1, 0, 0, imm));
      q.push_back(vec(0, src, 0, 0, 1, 0, 0, immm, f, 1, 0, 0, imm));
      q.push_back(vec(0, 0, 0, 0, 0, 1, 0, 0, f, 1, 0, 0, imm));
      q.push_back(vec(0, 0, dst, 0, 0, 0, 1, 0, f, 1, 0, 0, imm));
      q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, imm));
    end
    q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, bad, imm));
    foreach (q[i]) begin
      if (third) exp3_q.push_back(q[i]);
      else exp_q.push_back(q[i]);
    end
    if (!third) begin
      last_err = bad;
      last_imm = imm;
    end
  endtask

  task automatic sample(input int cyc);
    int drivers;
    drivers = $countones(RI_OUT) + int'(IMM_TRI) + int'(ALU_TRI);
    chk($sformatf("bus_onehot c%0d", cyc), 64'(drivers > 1), 64'(0));
    chk($sformatf("vec c%0d", cyc), 64'(obs), 64'(exp_q.pop_front()));
    if (exp3_q.size() > 0)
      chk($sformatf("vec3 c%0d", cyc), 64'(obs3), 64'(exp3_q.pop_front()));
  endtask

  // Driver: called at a negedge of an IDLE cycle; returns at the negedge of the
  // IDLE cycle that follows completion, so a following call is back-to-back.
  task automatic run_instr(input logic [3:0] op, input logic [5:0] p1, input logic [5:0] p2,
                           input bit hold, input int pulse_at, input bit with3);
    int cyc;
    model_instr(0, 4, op, p1, p2);
    if (with3) model_instr(1, 3, op, p1, p2);
    START = 1'b1; OPCODE = op; P1 = p1; P2 = p2;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
      sample(cyc);
      START  = hold || (cyc + 1 == pulse_at);
      OPCODE = 4'($urandom);
      P1     = 6'($urandom);
      P2     = 6'($urandom);
    end
  endtask

  task automatic idle_cycles(input int n);
    START = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("idle", 64'(obs), 64'(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, last_err, last_imm)));
    end
  endtask

  initial begin
    logic [3:0] op;
    logic [5:0] p1, p2;
    RESET_N = 1'b0; START = 1'b0; OPCODE = '0; P1 = '0; P2 = '0;
    last_err = 1'b0; last_imm = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outputs", 64'(obs), 64'(0));
    chk("reset_outputs3", 64'(obs3), 64'(0));
    RESET_N = 1'b1;
    idle_cycles(1);

    // ADD r3,r1 (valid with 4 registers, out of range with 3), then a valid op clears ERR
    run_instr(4'b0001, 6'd3, 6'd1, 0, 0, 1);
    run_instr(4'b0010, 6'd1, 6'd2, 0, 0, 1);
    idle_cycles(1);
    // immediate with negative value, immediate MOVE
    run_instr(4'b1000, 6'b000011, 6'b110101, 0, 0, 0);
    chk("imm_sext", 64'(IMM_OUT), 64'h0000_0000_0000_FFF5);
    run_instr(4'b1111, 6'd2, 6'b000111, 0, 0, 0);
    chk("imm_move", 64'(IMM_OUT), 64'h0000_0000_0000_0007);
    // index with bits above IDX_W set, then ERR clears on the next accepted START
    run_instr(4'b0011, 6'b010001, 6'd0, 0, 0, 0);
    run_instr(4'b0100, 6'd0, 6'd3, 0, 3, 0);
    // START held high: back-to-back instructions, register MOVE with P1==P2
    run_instr(4'b0101, 6'd2, 6'd0, 1, 0, 0);
    run_instr(4'b0111, 6'd2, 6'd2, 1, 0, 0);
    idle_cycles(2);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      p1 = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
      p2 = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
      if (op[3]) p2 = 6'($urandom);
      run_instr(op, p1, p2, 1'($urandom_range(0, 1)), $urandom_range(1, 6), 0);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end

    // asynchronous reset in the middle of EXEC
    START = 1'b1; OPCODE = 4'b0001; P1 = 6'd3; P2 = 6'd1;
    repeat (4) begin
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
    end
    chk("pre_reset_exec", 64'(ALU_REGO), 64'(1));
    #2 RESET_N = 1'b0;
    #1 chk("async_reset", 64'(obs), 64'(0));
    chk("async_reset_busy", 64'(BUSY), 64'(0));
    @(negedge CLK);
    RESET_N = 1'b1;
    last_err = 1'b0;
    last_imm = '0;
    idle_cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_ctrl_fsm.md
# reg_file_ctrl_fsm

Parametrised successor to the immediate-instruction control FSM. It sequences one instruction at a time through the shared-bus datapath: register file, ALU input/output registers and the tri-state bus drivers. It supports register-register, register-immediate and move operations on an NREG-entry register file, with a configurable data width. Out-of-range register indices are detected and flagged. The block sits between the instruction source (OPCODE/P1/P2/START) and the datapath enables.

## Interface
Parameters:
- DATA_W, 16, datapath/bus width
- NREG, 4, number of registers (2..16); IDX_W = clog2(NREG)
- PARAM_W, 6, width of P1/P2 (must be >= IDX_W and <= DATA_W)

Ports:
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  instruction request; sampled only in IDLE
- OPCODE  in  4  [3]=1 immediate mode, [2:0] ALU function; [2:0]=3'b111 is MOVE
- P1  in  PARAM_W  destination / first-source register index (low IDX_W bits)
- P2  in  PARAM_W  register-mode: second-source index; immediate-mode: immediate value
- PCINC  out  1  program-counter increment pulse
- RI_OUT  out  NREG  register n drives bus (one-hot or zero)
- RI_IN  out  NREG  register n loads from bus (one-hot or zero)
- ALU_REG1, ALU_REG2, ALU_REGO  out  1  load ALU operand A / operand B / result register
- ALU_TRI  out  1  ALU result register drives bus
- IMM_TRI  out  1  immediate drives bus
- IMM_OUT  out  DATA_W  sign-extended latched P2
- ALU_OP  out  3  ALU function
- BUSY  out  1  high in every state except IDLE
- FINISH  out  1  one-cycle completion pulse
- ERR  out  1  sticky index-range error

## Operation
- Moore outputs decoded from registered state. Inputs OPCODE/P1/P2 are latched on the edge that accepts START. They may change freely afterwards.
- States: IDLE, FETCH, LOAD_A, LOAD_B, EXEC, WRITE, MOVE, DONE.
- IDLE: START=1 -> FETCH, latch inputs, clear ERR. START while not IDLE is ignored (no queueing).
- FETCH: PCINC=1. Range check on the latched values:
  - P1 index >= NREG, or (register mode and P2 index >= NREG) -> DONE with ERR set.
  - Otherwise MOVE if OPCODE[2:0]=3'b111, else LOAD_A.
- LOAD_A: RI_OUT[P1]=1, ALU_REG1=1.
- LOAD_B: register mode RI_OUT[P2]=1; immediate mode IMM_TRI=1. ALU_REG2=1 in both cases.
- EXEC: ALU_REGO=1.
- WRITE: ALU_TRI=1, RI_IN[P1]=1.
- MOVE: source is RI_OUT[P2] (register mode) or IMM_TRI (immediate mode). RI_IN[P1]=1 in the same cycle. MOVE with P1==P2 in register mode is legal.
- DONE: FINISH=1 -> IDLE.
- ALU_OP = latched OPCODE[2:0] in LOAD_A..WRITE; 0 in all other states.
- IMM_OUT = sign-extend(latched P2) to DATA_W. It is 0 after reset and updates only on an accepted START.
- Bus invariant: at most one of {any RI_OUT bit, IMM_TRI, ALU_TRI} is high in any cycle.
- Index bits of P1/P2 above IDX_W must be zero; otherwise ERR (same path as an out-of-range index).

## Timing
- Reset (RESET_N=0, asynchronous):
  - State goes to IDLE immediately, including mid-instruction. The aborted instruction produces no FINISH and no RI_IN.
  - All outputs are 0, including ERR, IMM_OUT and BUSY.
- Cycle 0 is the START-accepting edge.
  - ALU op: FETCH c1, LOAD_A c2, LOAD_B c3, EXEC c4, WRITE c5, DONE (FINISH) c6, IDLE c7. Latency is 6 cycles.
  - MOVE: FETCH c1, MOVE c2, DONE c3.
  - Error: FETCH c1, DONE c2 with FINISH=1 and ERR=1. ERR holds until the next accepted START.
- Back-to-back: START held high through DONE is accepted on the IDLE cycle after DONE. The minimum instruction spacing is therefore 7 cycles (ALU) or 4 cycles (MOVE).
- PCINC is exactly one cycle per accepted START, error case included.

## Test plan
- Reset: RESET_N low mid-EXEC -> next sample shows all outputs 0 and BUSY=0. No FINISH follows.
- Register ADD: OPCODE=4'b0001, P1=3, P2=1, NREG=4 -> RI_OUT=4'b1000 with ALU_REG1 at c2; RI_OUT=4'b0010 with ALU_REG2 at c3; ALU_REGO at c4; ALU_TRI with RI_IN=4'b1000 at c5; FINISH at c6; ALU_OP=3'b001 from c2 through c5.
- Immediate: OPCODE=4'b1000, P1=6'b000011, P2=6'b110101 -> IMM_OUT=16'hFFF5; IMM_TRI and ALU_REG2 at c3; no RI_OUT in c3. OPCODE is changed to 4'b1001 at c1 and ALU_OP stays 3'b000.
- MOVE: OPCODE=4'b1111, P1=2, P2=6'b000111 -> c2 has IMM_TRI=1 and RI_IN=4'b0100; FINISH at c3; IMM_OUT=16'h0007.
- Range error: NREG=3, P1=3 -> c2 has FINISH=1 and ERR=1, no RI_IN/RI_OUT ever. Next valid START clears ERR.
- Busy/back-to-back: START pulsed in c3 is ignored. START held high -> second FETCH at c8. Bus one-hot invariant is asserted on every cycle.
